// File: rtl/hazard_stall_unit.sv
// Pipeline interlock: RAW stall detection against a 3-slot destination shadow, IF/ID squash, perf counters.
// Optional macro FORWARDING_EN: IX/MEM results are forwarded, so only a load in IX stalls the consumer.
module hazard_stall_unit #(
   parameter int CNT_W  = 16,
   parameter int NREG_W = 5
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              id_valid,
   input  logic [NREG_W-1:0] id_rs,
   input  logic [NREG_W-1:0] id_rt,
   input  logic              id_uses_rs,
   input  logic              id_uses_rt,
   input  logic [NREG_W-1:0] id_dest,
   input  logic              id_write_to_reg,
   input  logic              id_is_load,
   input  logic              ix_redirect,
   output logic              stall_out,
   output logic              pc_hold,
   output logic              ifid_hold,
   output logic              ifid_flush,
   output logic [1:0]        state_out,
   output logic [CNT_W-1:0]  stall_cnt,
   output logic [CNT_W-1:0]  flush_cnt
);

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_STALL = 2'd1,
      ST_FLUSH = 2'd2
   } state_t;

   localparam int SLOT_IX  = 0;
   localparam int SLOT_MEM = 1;
   localparam int SLOT_WB  = 2;

   logic              slot_v_reg    [3];
   logic [NREG_W-1:0] slot_dest_reg [3];
   logic              slot_ld_reg   [3];
   state_t            state_reg;
   logic [CNT_W-1:0]  stall_cnt_reg;
   logic [CNT_W-1:0]  flush_cnt_reg;

   logic [1:0] slot_eligible;
   logic [1:0] rs_match;
   logic [1:0] rt_match;
   logic       hit;
   logic       ix_bubble;
   logic       unused_slot_bits;

   // Only IX and MEM can hit: WB writes the register file before ID reads it.
   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_match
`ifdef FORWARDING_EN
         if (gi == SLOT_IX) begin : g_load_use
            assign slot_eligible[gi] = slot_v_reg[gi] & slot_ld_reg[gi];
         end else begin : g_forwarded
            assign slot_eligible[gi] = 1'b0;
         end
`else
         assign slot_eligible[gi] = slot_v_reg[gi];
`endif
         assign rs_match[gi] = slot_eligible[gi] && (slot_dest_reg[gi] == id_rs) && (id_rs != '0);
         assign rt_match[gi] = slot_eligible[gi] && (slot_dest_reg[gi] == id_rt) && (id_rt != '0);
      end
   endgenerate

   assign hit = id_valid & ((id_uses_rs & (|rs_match)) | (id_uses_rt & (|rt_match)));

   // A redirect squashes ID, so it overrides any pending stall.
   assign stall_out  = rst_n & hit & ~ix_redirect;
   assign pc_hold    = stall_out;
   assign ifid_hold  = stall_out;
   assign ifid_flush = rst_n & ix_redirect;
   assign ix_bubble  = stall_out | ix_redirect | ~id_valid;

   assign state_out = state_reg;
   assign stall_cnt = stall_cnt_reg;
   assign flush_cnt = flush_cnt_reg;

   // WB slot is kept for observability of the in-flight window but never compared.
   assign unused_slot_bits = ^{slot_v_reg[SLOT_WB], slot_dest_reg[SLOT_WB],
                               slot_ld_reg[SLOT_WB], slot_ld_reg[SLOT_MEM], slot_ld_reg[SLOT_IX]};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 3; i++) begin
            slot_v_reg[i]    <= 1'b0;
            slot_dest_reg[i] <= '0;
            slot_ld_reg[i]   <= 1'b0;
         end
         state_reg     <= ST_RUN;
         stall_cnt_reg <= '0;
         flush_cnt_reg <= '0;
      end else begin
         slot_v_reg[SLOT_WB]     <= slot_v_reg[SLOT_MEM];
         slot_dest_reg[SLOT_WB]  <= slot_dest_reg[SLOT_MEM];
         slot_ld_reg[SLOT_WB]    <= slot_ld_reg[SLOT_MEM];
         slot_v_reg[SLOT_MEM]    <= slot_v_reg[SLOT_IX];
         slot_dest_reg[SLOT_MEM] <= slot_dest_reg[SLOT_IX];
         slot_ld_reg[SLOT_MEM]   <= slot_ld_reg[SLOT_IX];

         if (ix_bubble) begin
            slot_v_reg[SLOT_IX]    <= 1'b0;
            slot_dest_reg[SLOT_IX] <= '0;
            slot_ld_reg[SLOT_IX]   <= 1'b0;
         end else begin
            slot_v_reg[SLOT_IX]    <= id_write_to_reg && (id_dest != '0);
            slot_dest_reg[SLOT_IX] <= id_dest;
            slot_ld_reg[SLOT_IX]   <= id_is_load;
         end

         if (ix_redirect) begin
            state_reg <= ST_FLUSH;
         end else if (stall_out) begin
            state_reg <= ST_STALL;
         end else begin
            state_reg <= ST_RUN;
         end

         if (stall_out && (stall_cnt_reg != {CNT_W{1'b1}})) begin
            stall_cnt_reg <= stall_cnt_reg + CNT_W'(1);
         end
         if (ifid_flush && (flush_cnt_reg != {CNT_W{1'b1}})) begin
            flush_cnt_reg <= flush_cnt_reg + CNT_W'(1);
         end
      end
   end

endmodule
